hack_mem_io: RTL



---
 rtl/hack_mem_io.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hack_mem_io.sv
// Data RAM plus memory-mapped UART TX (FIFO-buffered), LED register and
// synchronised switch input, sitting on the Hack cpu's M bus.
module hack_mem_io #(
  parameter int DW           = 16,
  parameter int AW           = 15,
  parameter int RAM_DEPTH    = 16384,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          writeM,
  input  logic [DW-1:0] outM,
  input  logic [AW-1:0] addressM,
  output logic [DW-1:0] inM,
  output logic          uart_tx,
  output logic [7:0]    led,
  input  logic [7:0]    sw
);
  localparam int RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW  = $clog2(CLKS_PER_BIT + 1);

  localparam logic [AW-1:0] A_TXDATA = AW'(16'h4000);
  localparam logic [AW-1:0] A_STATUS = AW'(16'h4001);
  localparam logic [AW-1:0] A_LED    = AW'(16'h4002);
  localparam logic [AW-1:0] A_SW     = AW'(16'h4003);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [DW-1:0] r_ram  [RAM_DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_tx;
  logic [7:0]    r_led;
  logic [7:0]    r_sw_meta, r_sw_sync;

  logic w_ram_sel, w_empty, w_full, w_busy, w_pop, w_push_req, w_push, w_baud_end;

  assign w_ram_sel  = (32'(addressM) < RAM_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_busy     = (r_state != S_IDLE);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_push_req = writeM && (addressM == A_TXDATA);
  // A full FIFO still accepts a byte when the FSM pops on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));

  assign uart_tx = r_tx;
  assign led     = r_led;

  always_ff @(posedge clk50m) begin
    if (writeM && w_ram_sel) r_ram[addressM[RAW-1:0]] <= outM;
  end

  always_ff @(posedge clk50m) begin
    if (w_push) r_fifo[r_wptr] <= outM[7:0];
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_led     <= 8'h00;
      r_sw_meta <= 8'h00;
      r_sw_sync <= 8'h00;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_push_req && !w_push)                 r_ovf <= 1'b1;
      else if (writeM && addressM == A_STATUS)   r_ovf <= 1'b0;
      if (writeM && addressM == A_LED)           r_led <= outM[7:0];
    end
  end

  // TX framing: the line level is registered so uart_tx never glitches.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= 8'h00;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
    end else begin
      r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_fifo[r_rptr];
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: if (w_baud_end) begin
          r_tx    <= r_shift[0];
          r_bit   <= 3'd0;
          r_state <= S_DATA;
        end
        S_DATA: if (w_baud_end) begin
          if (r_bit == 3'd7) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_bit   <= r_bit + 1'b1;
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
          end
        end
        S_STOP: if (w_baud_end) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    inM = '0;
    if (w_ram_sel) inM = r_ram[addressM[RAW-1:0]];
    else begin
      case (addressM)
        A_STATUS: inM = DW'({3'b000, 5'(r_count), 4'b0000, r_ovf, w_empty, w_full, w_busy});
        A_LED:    inM = DW'({8'h00, r_led});
        A_SW:     inM = DW'({8'h00, r_sw_sync});
        default:  ;
      endcase
    end
  end
endmodule
